// File: rtl/timer_pkg.sv
// Shared types and bus addresses for the DIV/TIMA/TMA/TAC timer.
package timer_pkg;

  typedef enum logic [1:0] {
    TimerIdle     = 2'd0,
    TimerOverflow = 2'd1,
    TimerReload   = 2'd2
  } timer_state_e;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

endpackage

// File: rtl/timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer on the CPU bus, with delayed TMA reload and IRQ.
// state    | meaning
// Idle     | TIMA counts on falling edges of the selected divider tap
// Overflow | TIMA reads 0x00 for 4 clk; reload from TMA and irq at ph=3
// Reload   | 4 clk after reload; TIMA writes ignored, TMA writes also land in TIMA
module timer
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        sel,
  output logic        irq_timer
);

  logic [15:0]  sys_cnt;
  logic [7:0]   tima, tima_nx;
  logic [7:0]   tma;
  logic [2:0]   tac;
  logic         tick_q;
  timer_state_e state, state_nx;
  logic [1:0]   ph, ph_nx;
  logic         irq_nx;

  logic tap_bit, tick, fall;
  logic wr_en, wr_div, wr_tima, wr_tma, wr_tac;

  assign sel = mem_enable && (mem_addr >= ADDR_DIV) && (mem_addr <= ADDR_TAC);

  assign wr_en   = sel && mem_write && (t_cycle == 2'd3);
  assign wr_div  = wr_en && (mem_addr == ADDR_DIV);
  assign wr_tima = wr_en && (mem_addr == ADDR_TIMA);
  assign wr_tma  = wr_en && (mem_addr == ADDR_TMA);
  assign wr_tac  = wr_en && (mem_addr == ADDR_TAC);

  always_comb begin
    tap_bit = 1'b0;
    case (tac[1:0])
      2'b00:   tap_bit = sys_cnt[9];
      2'b01:   tap_bit = sys_cnt[3];
      2'b10:   tap_bit = sys_cnt[5];
      default: tap_bit = sys_cnt[7];
    endcase
  end

  // A DIV clear or TAC change that drops the tap also reads as a falling edge here.
  assign tick = tac[2] & tap_bit;
  assign fall = tick_q & ~tick;

  always_comb begin
    mem_rdata = 8'hFF;
    if (sel) begin
      case (mem_addr)
        ADDR_DIV:  mem_rdata = sys_cnt[15:8];
        ADDR_TIMA: mem_rdata = tima;
        ADDR_TMA:  mem_rdata = tma;
        ADDR_TAC:  mem_rdata = {5'b11111, tac};
        default:   mem_rdata = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph + 2'd1;
    tima_nx  = tima;
    irq_nx   = 1'b0;
    case (state)
      TimerIdle: begin
        ph_nx = 2'd0;
        if (wr_tima) begin
          tima_nx = mem_wdata;
        end else if (fall) begin
          if (tima == 8'hFF) begin
            tima_nx  = 8'h00;
            state_nx = TimerOverflow;
          end else begin
            tima_nx = tima + 8'd1;
          end
        end
      end
      TimerOverflow: begin
        if (wr_tima) begin
          tima_nx  = mem_wdata;
          state_nx = TimerIdle;
          ph_nx    = 2'd0;
        end else if (ph == 2'd3) begin
          // A TMA write on the reload edge is forwarded straight into TIMA.
          tima_nx  = wr_tma ? mem_wdata : tma;
          irq_nx   = 1'b1;
          state_nx = TimerReload;
          ph_nx    = 2'd0;
        end
      end
      TimerReload: begin
        if (wr_tma) begin
          tima_nx = mem_wdata;
        end else if (fall) begin
          tima_nx = tima + 8'd1;
        end
        if (ph == 2'd3) begin
          state_nx = TimerIdle;
          ph_nx    = 2'd0;
        end
      end
      default: begin
        state_nx = TimerIdle;
        ph_nx    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_cnt   <= 16'h0000;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= 3'b000;
      tick_q    <= 1'b0;
      state     <= TimerIdle;
      ph        <= 2'd0;
      irq_timer <= 1'b0;
    end else begin
      sys_cnt   <= wr_div ? 16'h0000 : sys_cnt + 16'd1;
      tick_q    <= tick;
      if (wr_tma) tma <= mem_wdata;
      if (wr_tac) tac <= mem_wdata[2:0];
      tima      <= tima_nx;
      state     <= state_nx;
      ph        <= ph_nx;
      irq_timer <= irq_nx;
    end
  end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed vector table, overflow corner sequences,
// and randomized bus traffic against a cycle-level behavioural model.
module tb_timer;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] mem_addr = 16'h0000;
  logic        mem_enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  mem_wdata = 8'h00;
  logic [7:0]  mem_rdata;
  logic        sel;
  logic        irq_timer;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .t_cycle    (t_cycle),
    .mem_addr   (mem_addr),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .sel        (sel),
    .irq_timer  (irq_timer)
  );

  // Reference model: age is -1 when counting normally, 0..3 after an overflow
  // (TIMA parked at zero), 4..7 during the post-reload window.
  int m_cnt, m_tima, m_tma, m_tac, m_age;
  bit m_prev, m_irq;
  int tap_tbl[4] = '{9, 3, 5, 7};

  task automatic model_reset();
    m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_age = -1;
    m_prev = 0; m_irq = 0;
  endtask

  function automatic logic [7:0] model_read(input int a);
    case (a)
      16'hFF04: return 8'((m_cnt >> 8) & 255);
      16'hFF05: return 8'(m_tima);
      16'hFF06: return 8'(m_tma);
      16'hFF07: return 8'(248 | m_tac);
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic model_step();
    bit hit, tk, fall;
    int a, n_tima, n_age;
    bit n_irq;
    a   = int'(mem_addr);
    hit = mem_enable && mem_write && (t_cycle == 2'd3) && a >= 16'hFF04 && a <= 16'hFF07;
    tk  = ((m_tac & 4) != 0) && (((m_cnt >> tap_tbl[m_tac & 3]) & 1) != 0);
    fall = m_prev && !tk;
    n_tima = m_tima; n_age = m_age; n_irq = 0;
    if (m_age < 0) begin
      if (hit && a == 16'hFF05) n_tima = int'(mem_wdata);
      else if (fall) begin
        if (m_tima == 255) begin n_tima = 0; n_age = 0; end
        else n_tima = m_tima + 1;
      end
    end else if (m_age <= 3) begin
      if (hit && a == 16'hFF05) begin n_tima = int'(mem_wdata); n_age = -1; end
      else if (m_age == 3) begin
        n_tima = (hit && a == 16'hFF06) ? int'(mem_wdata) : m_tma;
        n_irq = 1; n_age = 4;
      end else n_age = m_age + 1;
    end else begin
      if (hit && a == 16'hFF06) n_tima = int'(mem_wdata);
      else if (fall) n_tima = (m_tima + 1) % 256;
      n_age = (m_age == 7) ? -1 : m_age + 1;
    end
    m_cnt  = (hit && a == 16'hFF04) ? 0 : (m_cnt + 1) % 65536;
    m_prev = tk;
    if (hit && a == 16'hFF06) m_tma = int'(mem_wdata);
    if (hit && a == 16'hFF07) m_tac = int'(mem_wdata) & 7;
    m_tima = n_tima; m_age = n_age; m_irq = n_irq;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit exp_sel;
    model_step();
    @(posedge clk);
    #1;
    t_cycle = t_cycle + 2'd1;
    exp_sel = mem_enable && mem_addr >= 16'hFF04 && mem_addr <= 16'hFF07;
    check("irq", irq_timer, m_irq);
    check("sel", sel, exp_sel);
    check("rdata", mem_rdata, exp_sel ? model_read(int'(mem_addr)) : 8'hFF);
  endtask

  task automatic idle(input int n);
    mem_write = 1'b0; mem_enable = 1'b1; mem_addr = ADDR_TIMA;
    repeat (n) cycle();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bit done;
    mem_addr = a; mem_wdata = d; mem_enable = 1'b1; mem_write = 1'b1;
    do begin
      done = (t_cycle == 2'd3);
      cycle();
    end while (!done);
    mem_write = 1'b0; mem_addr = ADDR_TIMA;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    mem_enable = 1'b1; mem_write = 1'b0; mem_addr = a;
    #1;
    check(name, mem_rdata, exp);
  endtask

  // Arms TMA=0xAB and TIMA=0xFF, returns just after TIMA rolls over to 0x00.
  task automatic overflow_seq();
    bit found;
    idle(8);
    bus_write(ADDR_TMA, 8'hAB);
    bus_write(ADDR_TIMA, 8'hFF);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (mem_rdata == 8'h00) found = 1;
    end
    check("ovf_reached", 16'(found), 16'd1);
  endtask

  task automatic wait_irq();
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      if (irq_timer) seen = 1;
    end
    check("irq_seen", 16'(seen), 16'd1);
  endtask

  typedef struct {
    string       name;
    bit          is_write;
    logic [15:0] addr;
    logic [7:0]  data;
    int          wait_clk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int irq_cnt;
    int exp_t;
    vecs.push_back('{"div_rst",  0, ADDR_DIV,  8'h00, 0,   8'h00});
    vecs.push_back('{"tima_rst", 0, ADDR_TIMA, 8'h00, 0,   8'h00});
    vecs.push_back('{"tma_rst",  0, ADDR_TMA,  8'h00, 0,   8'h00});
    vecs.push_back('{"tac_rst",  0, ADDR_TAC,  8'h00, 0,   8'hF8});
    vecs.push_back('{"w_div",    1, ADDR_DIV,  8'h00, 0,   8'h00});
    vecs.push_back('{"w_tac",    1, ADDR_TAC,  8'h05, 0,   8'h00});
    vecs.push_back('{"w_tima",   1, ADDR_TIMA, 8'h00, 0,   8'h00});
    vecs.push_back('{"tima_16",  0, ADDR_TIMA, 8'h00, 16,  8'h01});
    vecs.push_back('{"tima_256", 0, ADDR_TIMA, 8'h00, 240, 8'h10});
    vecs.push_back('{"div_256",  0, ADDR_DIV,  8'h00, 0,   8'h01});
    vecs.push_back('{"w_tma",    1, ADDR_TMA,  8'hAB, 0,   8'h00});
    vecs.push_back('{"tma_rd",   0, ADDR_TMA,  8'h00, 0,   8'hAB});
    vecs.push_back('{"tac_rd",   0, ADDR_TAC,  8'h00, 0,   8'hFD});

    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wait_clk > 0) idle(vecs[i].wait_clk);
      if (vecs[i].is_write) bus_write(vecs[i].addr, vecs[i].data);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Normal overflow: four clocks at 0x00, then reload with a single irq clock.
    overflow_seq();
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k < 4) begin
        check("ovf_hold", mem_rdata, 8'h00);
        check("ovf_no_irq", irq_timer, 1'b0);
      end
      if (k == 4) begin
        check("irq_pulse", irq_timer, 1'b1);
        check("reload_val", mem_rdata, 8'hAB);
      end
      if (k == 5) check("irq_one_clk", irq_timer, 1'b0);
    end

    // TIMA write during overflow cancels the reload and the irq.
    overflow_seq();
    bus_write(ADDR_TIMA, 8'h42);
    read_check("ovf_wr_tima", ADDR_TIMA, 8'h42);
    irq_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (irq_timer) irq_cnt++;
    end
    check("ovf_wr_no_irq", 16'(irq_cnt), 16'd0);

    // TIMA write during reload is dropped.
    overflow_seq();
    wait_irq();
    bus_write(ADDR_TIMA, 8'h42);
    read_check("rld_wr_tima", ADDR_TIMA, 8'hAB);

    // TMA write during reload also lands in TIMA.
    overflow_seq();
    wait_irq();
    bus_write(ADDR_TMA, 8'h77);
    read_check("rld_wr_tma_tima", ADDR_TIMA, 8'h77);
    read_check("rld_wr_tma_tma", ADDR_TMA, 8'h77);

    // DIV write while the tap bit is high produces one extra TIMA increment.
    idle(8);
    bus_write(ADDR_TIMA, 8'h10);
    mem_enable = 1'b1; mem_write = 1'b0; mem_addr = ADDR_TIMA;
    for (int g = 0; g < 64; g++) begin
      if (t_cycle == 2'd3 && (m_cnt & 15) >= 9 && (m_cnt & 15) <= 14) break;
      cycle();
    end
    check("div_align", 16'(t_cycle == 2'd3 && (m_cnt & 15) >= 9), 16'd1);
    exp_t = (m_tima + 1) % 256;
    bus_write(ADDR_DIV, 8'h5A);
    cycle();
    read_check("div_fall_tima", ADDR_TIMA, 8'(exp_t));
    read_check("div_cleared", ADDR_DIV, 8'h00);

    // Reset asserted in the middle of an overflow.
    overflow_seq();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_irq", irq_timer, 1'b0);
    read_check("rst_div", ADDR_DIV, 8'h00);
    read_check("rst_tima", ADDR_TIMA, 8'h00);
    read_check("rst_tma", ADDR_TMA, 8'h00);
    read_check("rst_tac", ADDR_TAC, 8'hF8);
    @(negedge clk);
    reset_n = 1'b1;
    irq_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (irq_timer) irq_cnt++;
    end
    check("rst_no_irq", 16'(irq_cnt), 16'd0);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] addrs[6];
      int sel_i;
      addrs = '{16'hFF04, 16'hFF05, 16'hFF06, 16'hFF07, 16'hFF03, 16'hFF08};
      sel_i = (($urandom % 8) < 2) ? 1 : int'($urandom % 6);
      mem_addr   = addrs[sel_i];
      mem_enable = ($urandom % 4) != 0;
      mem_write  = ($urandom % 3) == 0;
      mem_wdata  = 8'($urandom);
      if (sel_i == 1 && ($urandom % 2) == 1) mem_wdata = 8'hFC + 8'($urandom % 4);
      if (sel_i == 3 && ($urandom % 2) == 1) mem_wdata = 8'h05;
      if (sel_i == 0 && ($urandom % 4) != 0) mem_write = 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
